argmax_block: RTL

- Final GCN stage and the reader side of the combination block's aggregated-row interface.
- Waits for done_comb, then drives read_row to fetch each aggregated ADJ·FM·WM row in turn.
- Computes the argmax column of each row and stores the per-node class indices in a result register file.
- Streams each result as it is produced and raises done once every node is classified.

---
 rtl/argmax_block.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/argmax_block.sv
// argmax_block: last GCN stage. Once the combination block signals that its
// aggregated rows are final, this block reads them one per cycle, picks the
// argmax column of each, stores the class per node and streams each result.
//
// Stream handshake: row_valid is a one-cycle pulse that qualifies row_index and
// row_class in the same cycle. There is no ready; a consumer must take every
// pulse. read_row -> adj_fm_wm_row is a same-cycle combinational read.
//
// Start timing: done_comb is registered into start_q at the edge where it is
// seen high. The FSM enters SCAN on the following edge, and row 0 is captured
// one edge after that. The first result therefore appears after edge E0+2, and
// done rises after edge E0+FEATURE_ROWS+1, alongside the last row_valid.
module argmax_block #(
  parameter int FEATURE_ROWS      = 6,
  parameter int WEIGHT_COLS       = 3,
  parameter int DOT_PROD_WIDTH    = 16,
  parameter bit SIGNED_DATA       = 1'b0,
  parameter int FEATURE_WIDTH     = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1,
  parameter int MAX_ADDRESS_WIDTH = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         done_comb,
  input  logic [DOT_PROD_WIDTH-1:0]    adj_fm_wm_row [0:WEIGHT_COLS-1],
  output logic [FEATURE_WIDTH-1:0]     read_row,
  output logic                         row_valid,
  output logic [FEATURE_WIDTH-1:0]     row_index,
  output logic [MAX_ADDRESS_WIDTH-1:0] row_class,
  output logic [MAX_ADDRESS_WIDTH-1:0] max_addi_answer [0:FEATURE_ROWS-1],
  output logic                         done,
  output logic [1:0]                   state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [FEATURE_WIDTH-1:0] LAST_ROW = FEATURE_WIDTH'(FEATURE_ROWS - 1);

  logic [1:0]                   state_q, state_d;
  logic [FEATURE_WIDTH-1:0]     cnt_q, cnt_d;
  logic                         start_q;
  logic                         row_valid_q;
  logic [FEATURE_WIDTH-1:0]     row_index_q;
  logic [MAX_ADDRESS_WIDTH-1:0] row_class_q;
  logic                         done_q;
  logic [MAX_ADDRESS_WIDTH-1:0] ans_q [0:FEATURE_ROWS-1];

  logic                         scan;
  logic                         last_row;
  logic [DOT_PROD_WIDTH-1:0]    best_val;
  logic [MAX_ADDRESS_WIDTH-1:0] best_col;

  // Element compare, signedness chosen at elaboration; no arithmetic so no growth.
  function automatic logic col_greater(input logic [DOT_PROD_WIDTH-1:0] a,
                                       input logic [DOT_PROD_WIDTH-1:0] b);
    if (SIGNED_DATA) begin
      return $signed(a) > $signed(b);
    end else begin
      return a > b;
    end
  endfunction

  assign scan     = (state_q == S_SCAN);
  assign last_row = (cnt_q == LAST_ROW);

  // Linear argmax over the presented row; strict greater keeps the lowest index on ties.
  always_comb begin
    best_val = adj_fm_wm_row[0];
    best_col = '0;
    for (int c = 1; c < WEIGHT_COLS; c++) begin
      if (col_greater(adj_fm_wm_row[c], best_val)) begin
        best_val = adj_fm_wm_row[c];
        best_col = MAX_ADDRESS_WIDTH'(c);
      end
    end
  end

  // Next-state and row counter; the counter stops at LAST_ROW so it never leaves range.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          state_d = S_SCAN;
          cnt_d   = '0;
        end
      end
      S_SCAN: begin
        if (last_row) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + FEATURE_WIDTH'(1);
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Start sampling and FSM state; start_q only listens while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= (state_q == S_IDLE) ? done_comb : 1'b0;
    end
  end

  // Result stream and completion flag, one capture per SCAN cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_valid_q <= 1'b0;
      row_index_q <= '0;
      row_class_q <= '0;
      done_q      <= 1'b0;
    end else begin
      row_valid_q <= scan;
      if (scan) begin
        row_index_q <= cnt_q;
        row_class_q <= best_col;
      end
      if (scan && last_row) begin
        done_q <= 1'b1;
      end
    end
  end

  // Per-node class register file, written once per row during the scan.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < FEATURE_ROWS; n++) begin
        ans_q[n] <= '0;
      end
    end else if (scan) begin
      ans_q[cnt_q] <= best_col;
    end
  end

  assign read_row        = scan ? cnt_q : '0;
  assign row_valid       = row_valid_q;
  assign row_index       = row_index_q;
  assign row_class       = row_class_q;
  assign max_addi_answer = ans_q;
  assign done            = done_q;
  assign state_dbg       = state_q;

endmodule
